// File: rtl/conv3x3_stream_core.sv
// Streaming 3x3 valid-mode convolution over one HxW plane, with stride 1/2, bias, psum accumulation and ReLU.
// Optional macro CONV_SATURATE_EN clamps outputs to the signed DATA_W range; without it outputs wrap.
module conv3x3_stream_core #(
    parameter int DATA_W = 16,
    parameter int FRAC   = 10,
    parameter int MAX_W  = 256,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_h,
    input  logic [DIM_W-1:0]  cfg_w,
    input  logic              cfg_stride,
    input  logic              cfg_bias,
    input  logic              cfg_accum,
    input  logic              cfg_relu,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [DATA_W-1:0] din_data,
    input  logic              psum_valid,
    output logic              psum_ready,
    input  logic [DATA_W-1:0] psum_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_data,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);
    // Handshake: a word moves on din/psum/dout when valid && ready are both high at a rising clk edge;
    // a producer never waits for ready before raising valid, and dout_data is held while valid && !ready.
    localparam int ACC_W = 2*DATA_W + 4;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_LOAD_B, S_STREAM, S_FLUSH, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [DIM_W-1:0]   h_q, wd_q, r_q, c_q;
    logic               stride_q, bias_en_q, accum_q, relu_q;
    logic [3:0]         ld_q;
    logic [DATA_W-1:0]  wt_q [0:8];
    logic [DATA_W-1:0]  bias_q;
    logic [DATA_W-1:0]  lb0_q [0:MAX_W-1];
    logic [DATA_W-1:0]  lb1_q [0:MAX_W-1];
    logic [DATA_W-1:0]  win_q [0:2][0:2];
    logic [DATA_W-1:0]  col_new [0:2];
    logic               dout_valid_q;
    logic [DATA_W-1:0]  dout_data_q;
    logic               din_fire, last_col, last_pix, emit_next;
    logic signed [ACC_W-1:0] acc, res;
    logic [DATA_W-1:0]  res_out;
    logic               unused_bits;

    function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    function automatic logic signed [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                                        input logic [DATA_W-1:0] b);
        logic signed [2*DATA_W-1:0] ax, bx, p;
        ax = {{DATA_W{a[DATA_W-1]}}, a};
        bx = {{DATA_W{b[DATA_W-1]}}, b};
        p  = ax * bx;
        return {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
    endfunction

    assign din_fire  = din_valid && din_ready;
    assign last_col  = (c_q == wd_q - DIM_W'(1));
    assign last_pix  = last_col && (r_q == h_q - DIM_W'(1));
    // Decided from the pixel counters alone so din_ready never depends on din_valid.
    assign emit_next = (state_q == S_STREAM) && (r_q >= DIM_W'(2)) && (c_q >= DIM_W'(2)) &&
                       (!stride_q || (!r_q[0] && !c_q[0]));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LOAD_W;
            S_LOAD_W: if (din_fire && ld_q == 4'd8) state_d = bias_en_q ? S_LOAD_B : S_STREAM;
            S_LOAD_B: if (din_fire) state_d = S_STREAM;
            S_STREAM: if (din_fire && last_pix) state_d = S_FLUSH;
            S_FLUSH:  if (!dout_valid_q || dout_ready) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        din_ready = 1'b0;
        case (state_q)
            S_LOAD_W, S_LOAD_B: din_ready = 1'b1;
            S_STREAM: din_ready = (!dout_valid_q || dout_ready) &&
                                  (!emit_next || !accum_q || psum_valid);
            default:  din_ready = 1'b0;
        endcase
        psum_ready = din_valid && din_ready && emit_next && accum_q;
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q <= '0; wd_q <= '0; r_q <= '0; c_q <= '0; ld_q <= '0;
            stride_q <= 1'b0; bias_en_q <= 1'b0; accum_q <= 1'b0; relu_q <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                h_q <= cfg_h; wd_q <= cfg_w; stride_q <= cfg_stride;
                bias_en_q <= cfg_bias; accum_q <= cfg_accum; relu_q <= cfg_relu;
                ld_q <= '0; r_q <= '0; c_q <= '0;
            end
            if (state_q == S_LOAD_W && din_fire) ld_q <= ld_q + 4'd1;
            if (state_q == S_STREAM && din_fire) begin
                c_q <= last_col ? '0 : c_q + DIM_W'(1);
                if (last_col) r_q <= r_q + DIM_W'(1);
            end
            if (din_fire && emit_next) begin
                dout_valid_q <= 1'b1;
                dout_data_q  <= res_out;
            end else if (dout_ready) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    // Window row 0 is the oldest line (lb1), row 2 the incoming pixel's line.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD_W && din_fire) begin
            wt_q[ld_q] <= din_data;
            if (ld_q == 4'd8 && !bias_en_q) bias_q <= '0;
        end
        if (state_q == S_LOAD_B && din_fire) bias_q <= din_data;
        if (state_q == S_STREAM && din_fire) begin
            lb0_q[c_q] <= din_data;
            lb1_q[c_q] <= lb0_q[c_q];
            for (int k = 0; k < 3; k++) begin
                win_q[k][0] <= win_q[k][1];
                win_q[k][1] <= win_q[k][2];
                win_q[k][2] <= col_new[k];
            end
        end
    end

    always_comb begin
        col_new[0] = lb1_q[c_q];
        col_new[1] = lb0_q[c_q];
        col_new[2] = din_data;
        acc = sext(bias_q) <<< FRAC;
        if (accum_q) acc = acc + (sext(psum_data) <<< FRAC);
        for (int k = 0; k < 3; k++) begin
            acc = acc + mul_ext(wt_q[3*k],   win_q[k][1])
                      + mul_ext(wt_q[3*k+1], win_q[k][2])
                      + mul_ext(wt_q[3*k+2], col_new[k]);
        end
        res = acc >>> FRAC;
        if (relu_q && res[ACC_W-1]) res = '0;
    end

`ifdef CONV_SATURATE_EN
    always_comb begin
        res_out = res[DATA_W-1:0];
        if (res[ACC_W-1] && !(&res[ACC_W-2:DATA_W-1]))
            res_out = {1'b1, {(DATA_W-1){1'b0}}};
        else if (!res[ACC_W-1] && (|res[ACC_W-2:DATA_W-1]))
            res_out = {1'b0, {(DATA_W-1){1'b1}}};
    end
`else
    assign res_out = res[DATA_W-1:0];
`endif

    assign unused_bits = ^{acc[FRAC-1:0], res};
    assign dout_valid  = dout_valid_q;
    assign dout_data   = dout_data_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_conv3x3_stream_core.sv
// Bench for conv3x3_stream_core: directed passes plus randomized passes checked against
// a plain-arithmetic convolution model computed over the whole plane.
module tb_conv3x3_stream_core;
    localparam int DATA_W   = 16;
    localparam int FRAC     = 10;
    localparam int MAX_W    = 256;
    localparam int DIM_W    = 8;
    localparam int WAIT_MAX = 5000;

    logic              clk, rst_n, start;
    logic [DIM_W-1:0]  cfg_h, cfg_w;
    logic              cfg_stride, cfg_bias, cfg_accum, cfg_relu;
    logic              din_valid, din_ready;
    logic [DATA_W-1:0] din_data;
    logic              psum_valid, psum_ready;
    logic [DATA_W-1:0] psum_data;
    logic              dout_valid, dout_ready;
    logic [DATA_W-1:0] dout_data;
    logic              busy, done;
    logic [2:0]        unused_dbg_state;

    conv3x3_stream_core #(.DATA_W(DATA_W), .FRAC(FRAC), .MAX_W(MAX_W), .DIM_W(DIM_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_h(cfg_h), .cfg_w(cfg_w), .cfg_stride(cfg_stride), .cfg_bias(cfg_bias),
        .cfg_accum(cfg_accum), .cfg_relu(cfg_relu),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .busy(busy), .done(done), .dbg_state(unused_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pr_cnt = 0;
    always @(negedge clk) if (psum_ready) pr_cnt++;

    int cur_h, cur_w, cur_s, cur_bias, cur_accum, cur_relu;
    bit din_gaps, dout_rand, psum_hold, dout_hold;
    int wts [9];
    int bias_v;
    int pix [$];
    int ps  [$];
    logic [DATA_W-1:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic abort_run(input string tag);
        total++;
        bad++;
        $display("FAIL %s: wait expired", tag);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "bench aborted");
    endtask

    // scoreboard model: direct valid-mode convolution over the stored plane
    function automatic void build_expected();
        int s, n;
        longint acc, res;
        logic [DATA_W-1:0] q;
        s = cur_s ? 2 : 1;
        n = 0;
        exp_q.delete();
        for (int oy = 0; oy*s + 2 < cur_h; oy++) begin
            for (int ox = 0; ox*s + 2 < cur_w; ox++) begin
                acc = 0;
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++)
                        acc += longint'(wts[ky*3+kx]) * longint'(pix[(oy*s+ky)*cur_w + ox*s + kx]);
                if (cur_bias != 0)  acc += longint'(bias_v) <<< FRAC;
                if (cur_accum != 0) acc += longint'(ps[n]) <<< FRAC;
                res = acc >>> FRAC;
                if (cur_relu != 0 && res < 0) res = 0;
`ifdef CONV_SATURATE_EN
                if (res > 32767) res = 32767;
                else if (res < -32768) res = -32768;
`endif
                q = res[DATA_W-1:0];
                exp_q.push_back(q);
                n++;
            end
        end
    endfunction

    function automatic int n_outputs();
        int s;
        s = cur_s ? 2 : 1;
        return ((cur_h - 3) / s + 1) * ((cur_w - 3) / s + 1);
    endfunction

    function automatic void fill_const(input int wv, input int pv, input int bv);
        for (int i = 0; i < 9; i++) wts[i] = wv;
        bias_v = bv;
        pix.delete();
        for (int i = 0; i < cur_h*cur_w; i++) pix.push_back(pv);
        ps.delete();
        for (int i = 0; i < n_outputs(); i++) ps.push_back(100*(i+1));
    endfunction

    function automatic void fill_rand();
        for (int i = 0; i < 9; i++) wts[i] = int'($urandom_range(0, 4095)) - 2048;
        bias_v = int'($urandom_range(0, 65535)) - 32768;
        pix.delete();
        for (int i = 0; i < cur_h*cur_w; i++) pix.push_back(int'($urandom_range(0, 16383)) - 8192);
        ps.delete();
        for (int i = 0; i < n_outputs(); i++) ps.push_back(int'($urandom_range(0, 65535)) - 32768);
    endfunction

    task automatic set_cfg(input int h, input int w, input int s, input int b, input int a, input int r);
        cur_h = h; cur_w = w; cur_s = s; cur_bias = b; cur_accum = a; cur_relu = r;
    endtask

    // driver tasks
    task automatic send_din(input logic [DATA_W-1:0] v);
        int n;
        while (din_gaps && $urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
        din_data  = v;
        din_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!din_ready) begin
            n++;
            if (n > WAIT_MAX) abort_run("din_wait");
            @(negedge clk);
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    task automatic din_driver();
        for (int i = 0; i < 9; i++) send_din(DATA_W'(wts[i]));
        if (cur_bias != 0) send_din(DATA_W'(bias_v));
        for (int i = 0; i < pix.size(); i++) send_din(DATA_W'(pix[i]));
    endtask

    task automatic psum_driver();
        int n;
        if (cur_accum == 0) return;
        for (int i = 0; i < ps.size(); i++) begin
            if (psum_hold && i == 2) begin
                n = 0;
                @(negedge clk);
                while (!(din_valid && !din_ready)) begin
                    n++;
                    if (n > WAIT_MAX) abort_run("psum_stall_wait");
                    @(negedge clk);
                end
                for (int j = 0; j < 5; j++) begin
                    check_eq("psum_stall_din_ready", din_ready, 0);
                    @(negedge clk);
                end
                @(posedge clk); #1;
            end
            while (din_gaps && $urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
            psum_data  = DATA_W'(ps[i]);
            psum_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!psum_ready) begin
                n++;
                if (n > WAIT_MAX) abort_run("psum_wait");
                @(negedge clk);
            end
            @(posedge clk); #1;
            psum_valid = 1'b0;
        end
    endtask

    task automatic sink(input string name, input int n_exp);
        int got, cyc;
        bit held_done;
        logic [DATA_W-1:0] held, e;
        got = 0; cyc = 0; held_done = 0;
        dout_ready = dout_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        while (got < n_exp) begin
            if (dout_hold && got == 2 && !held_done) begin
                held_done  = 1;
                dout_ready = 1'b0;
                @(negedge clk);
                while (!dout_valid) begin
                    cyc++;
                    if (cyc > WAIT_MAX) abort_run("bp_wait");
                    @(negedge clk);
                end
                held = dout_data;
                for (int j = 0; j < 10; j++) begin
                    check_eq("bp_din_ready", din_ready, 0);
                    check_eq("bp_dout_hold", dout_data, held);
                    @(negedge clk);
                end
                @(posedge clk); #1;
                dout_ready = 1'b1;
            end
            @(negedge clk);
            if (dout_valid && dout_ready) begin
                e = exp_q.pop_front();
                check_eq({name, ":dout"}, dout_data, e);
                got++;
            end
            cyc++;
            if (cyc > WAIT_MAX) abort_run({name, ":dout_wait"});
            @(posedge clk); #1;
            dout_ready = dout_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        dout_ready = 1'b1;
    endtask

    task automatic run_pass(input string name);
        int n_exp, pr_base, s, cyc;
        bit exact, seen;
        build_expected();
        n_exp   = exp_q.size();
        s       = cur_s ? 2 : 1;
        exact   = ((cur_h - 3) % s == 0) && ((cur_w - 3) % s == 0);
        pr_base = pr_cnt;
        cfg_h = DIM_W'(cur_h); cfg_w = DIM_W'(cur_w); cfg_stride = cur_s[0];
        cfg_bias = cur_bias[0]; cfg_accum = cur_accum[0]; cfg_relu = cur_relu[0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fork
            din_driver();
            psum_driver();
            sink(name, n_exp);
        join
        if (exact) begin
            @(negedge clk);
            check_eq({name, ":done_timing"}, done, 1);
        end else begin
            seen = 0; cyc = 0;
            while (!seen && cyc < 200) begin
                @(negedge clk);
                seen = done;
                cyc++;
            end
            check_eq({name, ":done_seen"}, seen, 1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check_eq({name, ":done_pulse"}, done, 0);
        check_eq({name, ":busy_end"}, busy, 0);
        check_eq({name, ":dout_valid_end"}, dout_valid, 0);
        check_eq({name, ":psum_count"}, pr_cnt - pr_base, cur_accum != 0 ? n_exp : 0);
        check_eq({name, ":queue_empty"}, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, ":dout_valid"}, dout_valid, 0);
        check_eq({name, ":dout_data"}, dout_data, 0);
        check_eq({name, ":din_ready"}, din_ready, 0);
        check_eq({name, ":psum_ready"}, psum_ready, 0);
        check_eq({name, ":busy"}, busy, 0);
        check_eq({name, ":done"}, done, 0);
    endtask

    task automatic reset_mid_stream();
        set_cfg(5, 5, 0, 0, 0, 0);
        cfg_h = 8'd5; cfg_w = 8'd5; cfg_stride = 0; cfg_bias = 0; cfg_accum = 0; cfg_relu = 0;
        dout_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        din_valid = 1'b1;
        din_data  = 16'd1024;
        for (int i = 0; i < 9 + 14; i++) begin @(posedge clk); #1; end
        din_valid = 1'b0;
        @(negedge clk);
        check_eq("pre_rst:busy", busy, 1);
        check_eq("pre_rst:dout_valid", dout_valid, 1);
        check_eq("pre_rst:dout_data", dout_data, 9216);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        cfg_h = '0; cfg_w = '0; cfg_stride = 0; cfg_bias = 0; cfg_accum = 0; cfg_relu = 0;
        din_valid = 0; din_data = '0; psum_valid = 0; psum_data = '0; dout_ready = 1'b1;
        din_gaps = 0; dout_rand = 0; psum_hold = 0; dout_hold = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        set_cfg(5, 5, 0, 0, 0, 0); fill_const(1024, 1024, 0);     run_pass("s1_basic");
        set_cfg(5, 5, 1, 1, 0, 0); fill_const(1024, 1024, 512);   run_pass("s2_bias");
        set_cfg(5, 5, 0, 0, 0, 1); fill_const(-1024, 1024, 0);    run_pass("neg_relu");
        set_cfg(5, 5, 0, 0, 0, 0); fill_const(-1024, 1024, 0);    run_pass("neg_norelu");
        set_cfg(5, 5, 0, 0, 1, 0); fill_const(0, 77, 0);
        psum_hold = 1;                                             run_pass("accum_hold");
        psum_hold = 0;
        set_cfg(5, 5, 0, 0, 0, 0); fill_const(1024, 16384, 0);    run_pass("overflow");
        set_cfg(5, 5, 0, 0, 0, 0); fill_const(1024, 1024, 0);
        dout_hold = 1;                                             run_pass("dout_hold");
        dout_hold = 0;

        reset_mid_stream();
        set_cfg(5, 5, 0, 0, 0, 0); fill_const(1024, 1024, 0);     run_pass("after_rst");

        din_gaps = 1; dout_rand = 1;
        for (int t = 0; t < 12; t++) begin
            set_cfg($urandom_range(3, 9), (t == 5) ? 40 : $urandom_range(3, 12),
                    $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 1));
            fill_rand();
            run_pass($sformatf("rnd%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
